// File: rtl/stfq_rank_computer_if.sv
// Arrival, push, dequeue-feedback and config signals of the STFQ rank computer.
// The master side feeds arrivals and scheduler status; the slave side is the rank computer.
interface stfq_rank_computer_if #(
   parameter int FLOWS = 10,
   parameter int LEN_W = 16,
   parameter int WGT_W = 16
);
   logic             in_valid_1;
   logic             in_valid_2;
   logic             in_ready_1;
   logic             in_ready_2;
   logic [31:0]      in_value_1;
   logic [31:0]      in_value_2;
   logic [FLOWS-1:0] in_flow_1;
   logic [FLOWS-1:0] in_flow_2;
   logic [LEN_W-1:0] in_len_1;
   logic [LEN_W-1:0] in_len_2;
   logic             push_1;
   logic             push_2;
   logic [31:0]      push_rank_1;
   logic [31:0]      push_rank_2;
   logic [31:0]      push_value_1;
   logic [31:0]      push_value_2;
   logic [FLOWS-1:0] push_flow_1;
   logic [FLOWS-1:0] push_flow_2;
   logic             can_push_1;
   logic             can_push_2;
   logic             deq_valid;
   logic [31:0]      deq_rank;
   logic             cfg_we;
   logic [FLOWS-1:0] cfg_flow;
   logic [WGT_W-1:0] cfg_weight;
   logic [15:0]      drop_count;
   logic [31:0]      vtime;

   modport master (
      output in_valid_1, in_valid_2, in_value_1, in_value_2, in_flow_1, in_flow_2,
             in_len_1, in_len_2, can_push_1, can_push_2, deq_valid, deq_rank,
             cfg_we, cfg_flow, cfg_weight,
      input  in_ready_1, in_ready_2, push_1, push_2, push_rank_1, push_rank_2,
             push_value_1, push_value_2, push_flow_1, push_flow_2, drop_count, vtime
   );

   modport slave (
      input  in_valid_1, in_valid_2, in_value_1, in_value_2, in_flow_1, in_flow_2,
             in_len_1, in_len_2, can_push_1, can_push_2, deq_valid, deq_rank,
             cfg_we, cfg_flow, cfg_weight,
      output in_ready_1, in_ready_2, push_1, push_2, push_rank_1, push_rank_2,
             push_value_1, push_value_2, push_flow_1, push_flow_2, drop_count, vtime
   );
endinterface

// File: rtl/stfq_rank_computer.sv
// Start-time fair queueing rank tagger: two arrivals per cycle get start tags from
// per-flow finish times and a virtual time advanced by dequeue feedback.
module stfq_rank_computer #(
   parameter int FLOWS = 10,
   parameter int LEN_W = 16,
   parameter int WGT_W = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   stfq_rank_computer_if.slave bus
);
   localparam int PROD_W = LEN_W + WGT_W;

   logic [31:0]      vt_r;
   logic [31:0]      finish_r [FLOWS];
   logic [WGT_W-1:0] weight_r [FLOWS];
   logic [15:0]      drop_r;

   logic             ready_1_s, ready_2_s, acc_1_s, acc_2_s, ok_1_s, ok_2_s, same_s, cfg_ok_s;
   logic [31:0]      fin_1_s, fin_2_s, prev_2_s, start_1_s, start_2_s, end_1_s, end_2_s;
   logic [WGT_W-1:0] wgt_1_s, wgt_2_s;
   logic [16:0]      drop_sum_s;
   logic [15:0]      drop_next_s;

   function automatic logic is_onehot(input logic [FLOWS-1:0] f);
      return $countones(f) == 32'sd1;
   endfunction

   function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic [31:0] scaled_len(input logic [LEN_W-1:0] len, input logic [WGT_W-1:0] w);
      logic [PROD_W-1:0] p;
      p = PROD_W'(len) * PROD_W'(w);
      return 32'(p);
   endfunction

   // Ready, acceptance and start/finish tag computation for both channels
   always_comb begin
      fin_1_s = 32'h0;
      fin_2_s = 32'h0;
      wgt_1_s = {WGT_W{1'b0}};
      wgt_2_s = {WGT_W{1'b0}};
      for (int f = 0; f < FLOWS; f++) begin
         fin_1_s = fin_1_s | (finish_r[f] & {32{bus.in_flow_1[f]}});
         fin_2_s = fin_2_s | (finish_r[f] & {32{bus.in_flow_2[f]}});
         wgt_1_s = wgt_1_s | (weight_r[f] & {WGT_W{bus.in_flow_1[f]}});
         wgt_2_s = wgt_2_s | (weight_r[f] & {WGT_W{bus.in_flow_2[f]}});
      end
      // channel 2 may only go when channel 1 is not stalled, keeping arrival order
      ready_1_s = rst_n & bus.can_push_1;
      ready_2_s = rst_n & (bus.in_valid_1 ? (bus.can_push_1 & bus.can_push_2) : bus.can_push_1);
      acc_1_s   = bus.in_valid_1 & ready_1_s;
      acc_2_s   = bus.in_valid_2 & ready_2_s;
      ok_1_s    = acc_1_s & is_onehot(bus.in_flow_1);
      ok_2_s    = acc_2_s & is_onehot(bus.in_flow_2);
      same_s    = ok_1_s & (bus.in_flow_2 == bus.in_flow_1);
      start_1_s = max32(vt_r, fin_1_s);
      end_1_s   = sat_add(start_1_s, scaled_len(bus.in_len_1, wgt_1_s));
      prev_2_s  = same_s ? end_1_s : fin_2_s;
      start_2_s = max32(vt_r, prev_2_s);
      end_2_s   = sat_add(start_2_s, scaled_len(bus.in_len_2, wgt_2_s));
      cfg_ok_s  = bus.cfg_we & is_onehot(bus.cfg_flow);
      drop_sum_s = {1'b0, drop_r} + {16'h0, acc_1_s & ~ok_1_s} + {16'h0, acc_2_s & ~ok_2_s};
      drop_next_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
   end

   assign bus.in_ready_1   = ready_1_s;
   assign bus.in_ready_2   = ready_2_s;
   assign bus.push_1       = ok_1_s;
   assign bus.push_2       = ok_2_s;
   assign bus.push_rank_1  = start_1_s;
   assign bus.push_rank_2  = start_2_s;
   assign bus.push_value_1 = bus.in_value_1;
   assign bus.push_value_2 = bus.in_value_2;
   assign bus.push_flow_1  = bus.in_flow_1;
   assign bus.push_flow_2  = bus.in_flow_2;
   assign bus.drop_count   = drop_r;
   assign bus.vtime        = vt_r;

   // Virtual time, per-flow finish tags, weights and drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vt_r   <= 32'h0;
         drop_r <= 16'h0;
         for (int f = 0; f < FLOWS; f++) begin
            finish_r[f] <= 32'h0;
            weight_r[f] <= {{(WGT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         if (bus.deq_valid) begin
            vt_r <= max32(vt_r, bus.deq_rank);
         end else begin
            vt_r <= vt_r;
         end
         drop_r <= drop_next_s;
         for (int f = 0; f < FLOWS; f++) begin
            if (ok_2_s && bus.in_flow_2[f]) begin
               finish_r[f] <= end_2_s;
            end else if (ok_1_s && bus.in_flow_1[f]) begin
               finish_r[f] <= end_1_s;
            end else begin
               finish_r[f] <= finish_r[f];
            end
            if (cfg_ok_s && bus.cfg_flow[f]) begin
               weight_r[f] <= bus.cfg_weight;
            end else begin
               weight_r[f] <= weight_r[f];
            end
         end
      end
   end
endmodule

// File: doc/stfq_rank_computer.md
# stfq_rank_computer

Start-time fair queueing (STFQ) rank computer that sits directly upstream of the two-port PIFO flow scheduler. It takes up to two packet arrivals per cycle, tags each with a start-time rank from per-flow finish-time state and a global virtual time, and drives the scheduler's `push_1`/`push_2` ports in the same cycle. It respects the scheduler's `can_push_1`/`can_push_2` backpressure and advances virtual time from dequeue feedback.

## Interface
- `FLOWS`, 10: number of flows; flow IDs are one-hot `[FLOWS-1:0]`, as on the scheduler.
- `LEN_W`, 16: packet length width.
- `WGT_W`, 16: per-flow weight width; `LEN_W + WGT_W <= 32`.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid_1`, `in_valid_2` in 1 each: arrival on channel k.
- `in_ready_1`, `in_ready_2` out 1 each: channel k is accepted this cycle.
- `in_value_1`, `in_value_2` in 32 each: payload, passed through unchanged.
- `in_flow_1`, `in_flow_2` in FLOWS each: one-hot flow ID.
- `in_len_1`, `in_len_2` in LEN_W each: packet length.
- `push_1`, `push_2` out 1 each: to the scheduler's `push_k`.
- `push_rank_1`, `push_rank_2` out 32 each: computed start tag.
- `push_value_1`, `push_value_2` out 32 each: equal to `in_value_k`.
- `push_flow_1`, `push_flow_2` out FLOWS each: equal to `in_flow_k`.
- `can_push_1`, `can_push_2` in 1 each: from the scheduler.
- `deq_valid` in 1: a packet with rank `deq_rank` entered service.
- `deq_rank` in 32: rank of the dequeued packet.
- `cfg_we` in 1: weight write enable.
- `cfg_flow` in FLOWS: one-hot target flow for the weight write.
- `cfg_weight` in WGT_W: new weight for that flow.
- `drop_count` out 16: arrivals dropped for a malformed flow ID; saturates at 0xFFFF.
- `vtime` out 32: current virtual time.

## Operation
- State:
  - `vt` (32 bits).
  - `finish[f]` (32 bits each).
  - `weight[f]` (WGT_W bits each).
  - `drop_count`.
- Ready:
  - `in_ready_1 = can_push_1`.
  - `in_ready_2 = in_valid_1 ? can_push_2 : can_push_1`.
  - If channel 1 is not accepted, channel 2 is not accepted either (`in_ready_2 = 0`). This preserves arrival order.
  - Ready does not depend on `in_valid_2` or on the flow IDs.
- An arrival is accepted when `in_valid_k && in_ready_k`.
- Malformed flow ID: an accepted arrival whose flow is not exactly one-hot (zero bits or more than one bit set) is dropped. For a dropped arrival:
  - `push_k = 0`.
  - No state update.
  - `drop_count` increments by 1 per dropped arrival, so 2 if both channels drop in the same cycle.
- Rank computation, combinational from the registered state:
  - `S1 = max(vt, finish[f1])`.
  - `F1 = sat32(S1 + len1*weight[f1])`.
- Same-flow rule: if channel 2's flow equals channel 1's flow and channel 1 is accepted and well-formed, channel 2 uses `F1` in place of `finish[f2]`. Then `S2 = max(vt, F1)` and `F2 = sat32(S2 + len2*weight)`.
- Push outputs: `push_k = accepted && well-formed`; `push_rank_k = S_k`. Value and flow pass straight through.
- Update on the clock edge:
  - `finish[f_k] <= F_k` for each pushed channel. When both channels carry the same flow, `F2` wins.
  - If `deq_valid`: `vt <= max(vt, deq_rank)`. Virtual time never decreases.
- Config write:
  - `cfg_we` with a one-hot `cfg_flow` writes `weight`; a non-one-hot `cfg_flow` is ignored.
  - A weight write takes effect from the next cycle.
  - A weight write in the same cycle as an arrival on that flow: the arrival uses the old weight.
- Arithmetic:
  - Product is `LEN_W + WGT_W` bits, zero-extended to 32.
  - The sum saturates at 0xFFFF_FFFF; no wrap-around.
  - All comparisons are unsigned.

## Timing
- Zero latency from arrival to push. `push_*`, `in_ready_*` and the ranks are combinational from the inputs and registered state.
- State updates take effect on the next `posedge clk`.
- Reset: asserting `rst_n = 0` immediately, regardless of `clk`, sets:
  - `vt = 0`, all `finish = 0`, all `weight = 1`, `drop_count = 0`.
  - `push_1 = push_2 = 0` and `in_ready_1 = in_ready_2 = 0`, forced while in reset.
- Reset mid-operation discards all state; there is no partial update on the edge where reset is asserted.
- The first accepted arrival is allowed in the cycle `rst_n` is sampled high.
- `deq_valid` and arrivals in the same cycle: the ranks use the old `vt`, and the new `vt` applies from the next cycle.

## Test plan
- Reset and defaults:
  - Stimulus: `rst_n = 0` mid-cycle, then release; arrival flow=0b1, len=100.
  - Required: `push_rank_1 = 0`; next cycle `finish[0] = 100`.
- Same-flow pair:
  - Stimulus: weights 1; both channels on flow 2, len 10 and len 20, `vt = 0`.
  - Required: ranks 0 and 10; `finish[2] = 30` afterwards.
- Virtual time:
  - Stimulus: `deq_valid` with `deq_rank = 500`; next cycle an arrival on an idle flow.
  - Required: rank 500; a later `deq_rank = 200` leaves `vt` at 500.
- Backpressure:
  - Stimulus: `can_push_1 = 1`, `can_push_2 = 0`, both channels valid.
  - Required: only `push_1`; `in_ready_2 = 0`; channel-2 state unchanged.
  - Stimulus: `can_push_1 = 0`, channel 2 alone.
  - Required: not accepted.
- Malformed flow:
  - Stimulus: flow 0b0000000000 on channel 1 and 0b0000000011 on channel 2, both ready.
  - Required: no push; `drop_count` goes 0 to 2.
- Saturation and weight:
  - Stimulus: `weight[4] = 0xFFFF` via cfg; len 0xFFFF arrivals repeated on flow 4.
  - Required: `finish[4]` climbs and saturates at 0xFFFF_FFFF; ranks never wrap.
